// File: rtl/tcam_pkg.sv
// Shared types and default widths for the TCAM sequencing controller.
package tcam_pkg;

  localparam int ADDR_W      = 28;
  localparam int DATA_W      = 32;
  localparam int WADDR_W     = 10;
  localparam int PMA_W       = 6;
  localparam int CLEAR_WORDS = 1024;
  localparam int CLR_W       = $clog2(CLEAR_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    S_ISSUE,
    S_WAIT,
    RESULT,
    CLEAR
  } state_t;

endpackage

// File: rtl/tcam_ctrl_if.sv
// Requester handshakes plus macro pins for tcam_ctrl. The slave modport is the
// controller side; the master modport is the requester / macro side.
interface tcam_ctrl_if;
  import tcam_pkg::*;

  logic               in_s_valid;
  logic               out_s_ready;
  logic [ADDR_W-1:0]  in_s_key;

  logic               out_r_valid;
  logic               in_r_ready;
  logic [PMA_W-1:0]   out_r_pma;

  logic               in_w_valid;
  logic               out_w_ready;
  logic [WADDR_W-1:0] in_w_addr;
  logic [DATA_W-1:0]  in_w_data;
  logic [3:0]         in_w_mask;

  logic               in_clear;
  logic               out_busy;

  logic               out_tcam_csb;
  logic               out_tcam_web;
  logic [3:0]         out_tcam_wmask;
  logic [ADDR_W-1:0]  out_tcam_addr;
  logic [DATA_W-1:0]  out_tcam_wdata;
  logic [PMA_W-1:0]   in_tcam_pma;

  modport slave (
    input  in_s_valid, in_s_key, in_r_ready,
    input  in_w_valid, in_w_addr, in_w_data, in_w_mask,
    input  in_clear, in_tcam_pma,
    output out_s_ready, out_r_valid, out_r_pma, out_w_ready, out_busy,
    output out_tcam_csb, out_tcam_web, out_tcam_wmask, out_tcam_addr, out_tcam_wdata
  );

  modport master (
    output in_s_valid, in_s_key, in_r_ready,
    output in_w_valid, in_w_addr, in_w_data, in_w_mask,
    output in_clear, in_tcam_pma,
    input  out_s_ready, out_r_valid, out_r_pma, out_w_ready, out_busy,
    input  out_tcam_csb, out_tcam_web, out_tcam_wmask, out_tcam_addr, out_tcam_wdata
  );

endinterface

// File: rtl/tcam_arb.sv
// IDLE-state arbitration between search, write and a pending clear, with
// write-starvation tracking.
module tcam_arb
  import tcam_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic idle,
  input  logic clearing,
  input  logic in_clear,
  input  logic s_valid,
  input  logic w_valid,
  output logic s_ready,
  output logic w_ready,
  output logic grant_s,
  output logic grant_w,
  output logic grant_clr
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            clear_pend;
  logic            starved;

  assign starved = w_valid && (starve_cnt == SC_W'(STARVE_MAX));

  // Search normally wins; a write may still slip in when no search is asking.
  always_comb begin
    s_ready   = 1'b0;
    w_ready   = 1'b0;
    grant_clr = 1'b0;
    if (idle && !in_rst) begin
      if (clear_pend) begin
        grant_clr = 1'b1;
      end else if (starved) begin
        w_ready = 1'b1;
      end else begin
        s_ready = 1'b1;
        w_ready = !s_valid;
      end
    end
  end

  assign grant_s = s_valid && s_ready;
  assign grant_w = w_valid && w_ready;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      starve_cnt <= '0;
      clear_pend <= 1'b0;
    end else begin
      if (!w_valid || grant_w) begin
        starve_cnt <= '0;
      end else if (grant_s && (starve_cnt != SC_W'(STARVE_MAX))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      if (grant_clr) begin
        clear_pend <= 1'b0;
      end else if (in_clear && !clearing) begin
        clear_pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tcam_ctrl.sv
// Sequences searches, writes and a full-array clear onto the single TCAM port.
// All macro pins and result outputs are registered from next-state values.
//
// state   | meaning
// IDLE    | arbitrate, macro pins idle
// WRITE   | one macro write cycle
// S_ISSUE | one macro search cycle
// S_WAIT  | wait for macro match latency, capture pma on last edge
// RESULT  | hold result until accepted
// CLEAR   | write zeros to every macro word
module tcam_ctrl
  import tcam_pkg::*;
#(
  parameter int SEARCH_LAT = 1,
  parameter int STARVE_MAX = 4
) (
  input logic        in_clk,
  input logic        in_rst,
  tcam_ctrl_if.slave bus
);

  localparam int LAT_W = 2;

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt, lat_nxt;
  logic [CLR_W-1:0]   clr_cnt, clr_nxt;

  logic               csb_q, csb_nxt;
  logic               web_q, web_nxt;
  logic [3:0]         wmask_q, wmask_nxt;
  logic [ADDR_W-1:0]  addr_q, addr_nxt;
  logic [DATA_W-1:0]  wdata_q, wdata_nxt;
  logic               r_valid_q, r_valid_nxt;
  logic [PMA_W-1:0]   r_pma_q, r_pma_nxt;
  logic               busy_q, busy_nxt;

  logic               s_ready, w_ready;
  logic               grant_s, grant_w, grant_clr;

  tcam_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .in_clk    (in_clk),
    .in_rst    (in_rst),
    .idle      (state == IDLE),
    .clearing  (state == CLEAR),
    .in_clear  (bus.in_clear),
    .s_valid   (bus.in_s_valid),
    .w_valid   (bus.in_w_valid),
    .s_ready   (s_ready),
    .w_ready   (w_ready),
    .grant_s   (grant_s),
    .grant_w   (grant_w),
    .grant_clr (grant_clr)
  );

  assign bus.out_s_ready    = s_ready;
  assign bus.out_w_ready    = w_ready;
  assign bus.out_r_valid    = r_valid_q;
  assign bus.out_r_pma      = r_pma_q;
  assign bus.out_busy       = busy_q;
  assign bus.out_tcam_csb   = csb_q;
  assign bus.out_tcam_web   = web_q;
  assign bus.out_tcam_wmask = wmask_q;
  assign bus.out_tcam_addr  = addr_q;
  assign bus.out_tcam_wdata = wdata_q;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      clr_cnt   <= '0;
      csb_q     <= 1'b1;
      web_q     <= 1'b1;
      wmask_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      r_valid_q <= 1'b0;
      r_pma_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      lat_cnt   <= lat_nxt;
      clr_cnt   <= clr_nxt;
      csb_q     <= csb_nxt;
      web_q     <= web_nxt;
      wmask_q   <= wmask_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      r_valid_q <= r_valid_nxt;
      r_pma_q   <= r_pma_nxt;
      busy_q    <= busy_nxt;
    end
  end

  // Pin values are chosen for the state being entered so they line up with it.
  always_comb begin
    state_nxt = state;
    lat_nxt   = lat_cnt;
    clr_nxt   = clr_cnt;
    csb_nxt   = 1'b1;
    web_nxt   = 1'b1;
    wmask_nxt = '0;
    addr_nxt  = '0;
    wdata_nxt = '0;
    r_pma_nxt = r_pma_q;

    case (state)
      IDLE: begin
        if (grant_clr) begin
          state_nxt = CLEAR;
          clr_nxt   = '0;
          csb_nxt   = 1'b0;
          web_nxt   = 1'b0;
          wmask_nxt = 4'hF;
        end else if (grant_w) begin
          state_nxt = WRITE;
          csb_nxt   = 1'b0;
          web_nxt   = 1'b0;
          wmask_nxt = bus.in_w_mask;
          addr_nxt  = {{(ADDR_W - WADDR_W){1'b0}}, bus.in_w_addr};
          wdata_nxt = bus.in_w_data;
        end else if (grant_s) begin
          state_nxt = S_ISSUE;
          csb_nxt   = 1'b0;
          addr_nxt  = bus.in_s_key;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
        lat_nxt   = LAT_W'(SEARCH_LAT - 1);
      end
      S_WAIT: begin
        if (lat_cnt == '0) begin
          state_nxt = RESULT;
          r_pma_nxt = bus.in_tcam_pma;
        end else begin
          lat_nxt = lat_cnt - 1'b1;
        end
      end
      RESULT: begin
        if (bus.in_r_ready) begin
          state_nxt = IDLE;
        end
      end
      CLEAR: begin
        if (clr_cnt == CLR_W'(CLEAR_WORDS - 1)) begin
          state_nxt = IDLE;
        end else begin
          clr_nxt   = clr_cnt + 1'b1;
          csb_nxt   = 1'b0;
          web_nxt   = 1'b0;
          wmask_nxt = 4'hF;
          addr_nxt  = ADDR_W'(clr_cnt + 1'b1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    r_valid_nxt = (state_nxt == RESULT);
    busy_nxt    = (state_nxt == CLEAR);
  end

endmodule

// File: tb/tb_tcam_ctrl.sv
// Bench for tcam_ctrl: vector table, directed corner sequences, then a
// randomized phase against a transaction-level model.
module tb_tcam_ctrl;
  import tcam_pkg::*;

  localparam int SEARCH_LAT = 1;
  localparam int STARVE_MAX = 4;

  logic in_clk = 1'b0;
  logic in_rst = 1'b1;

  tcam_ctrl_if bus();

  tcam_ctrl #(.SEARCH_LAT(SEARCH_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .in_clk (in_clk),
    .in_rst (in_rst),
    .bus    (bus)
  );

  always #5 in_clk = ~in_clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Macro behaviour: match address is a fixed function of the key.
  function automatic logic [PMA_W-1:0] pma_of(input logic [ADDR_W-1:0] key);
    if (key == 28'h0ABCDEF) return 6'd17;
    return key[5:0] ^ key[27:22];
  endfunction

  logic [PMA_W-1:0] pma_pipe [SEARCH_LAT] = '{default: '0};
  always @(posedge in_clk) begin
    if (bus.out_tcam_csb == 1'b0 && bus.out_tcam_web == 1'b1)
      pma_pipe[0] <= pma_of(bus.out_tcam_addr);
    for (int i = 1; i < SEARCH_LAT; i++) pma_pipe[i] <= pma_pipe[i-1];
  end
  assign bus.in_tcam_pma = pma_pipe[SEARCH_LAT-1];

  typedef struct {
    bit               is_wr;
    logic [ADDR_W-1:0] key;
    logic [9:0]       waddr;
    logic [31:0]      wdata;
    logic [3:0]       wmask;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0]      exp_wdata;
    logic [3:0]       exp_wmask;
    logic             exp_web;
    logic [5:0]       exp_pma;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, bad, got;
    logic [5:0] pma_got;
    string order;
    bit free_m, exp_sr, exp_wr, gs, gw, starve_hit;
    int free_at, res_due, starve, op_cyc;
    bit res_pend, op_v, op_wr;
    logic [5:0] res_pma;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0] op_data;
    logic [3:0] op_mask;
    logic [ADDR_W-1:0] k;

    vecs[0] = '{1'b1, 28'h0, 10'h2C5, 32'hDEADBEEF, 4'h5, 28'h00002C5, 32'hDEADBEEF, 4'h5, 1'b0, 6'h0};
    vecs[1] = '{1'b1, 28'h0, 10'h3FF, 32'hFFFFFFFF, 4'hF, 28'h00003FF, 32'hFFFFFFFF, 4'hF, 1'b0, 6'h0};
    vecs[2] = '{1'b1, 28'h0, 10'h000, 32'h12345678, 4'h0, 28'h0000000, 32'h12345678, 4'h0, 1'b0, 6'h0};
    vecs[3] = '{1'b0, 28'h0ABCDEF, 10'h0, 32'h0, 4'h0, 28'h0ABCDEF, 32'h0, 4'h0, 1'b1, 6'h11};
    vecs[4] = '{1'b0, 28'hFFFFFFF, 10'h0, 32'h0, 4'h0, 28'hFFFFFFF, 32'h0, 4'h0, 1'b1, 6'h00};
    vecs[5] = '{1'b0, 28'hFC00000, 10'h0, 32'h0, 4'h0, 28'hFC00000, 32'h0, 4'h0, 1'b1, 6'h3F};
    vecs[6] = '{1'b0, 28'h0000001, 10'h0, 32'h0, 4'h0, 28'h0000001, 32'h0, 4'h0, 1'b1, 6'h01};

    bus.in_s_valid = 0; bus.in_s_key = '0; bus.in_r_ready = 0;
    bus.in_w_valid = 0; bus.in_w_addr = '0; bus.in_w_data = '0; bus.in_w_mask = '0;
    bus.in_clear = 0;

    // reset values while reset is held, with requests asserted
    repeat (2) @(negedge in_clk);
    bus.in_s_valid = 1; bus.in_w_valid = 1;
    #1;
    check("rst_csb", bus.out_tcam_csb, 1);
    check("rst_web", bus.out_tcam_web, 1);
    check("rst_addr", bus.out_tcam_addr, 0);
    check("rst_rvalid", bus.out_r_valid, 0);
    check("rst_busy", bus.out_busy, 0);
    check("rst_readys", {bus.out_s_ready, bus.out_w_ready}, 0);
    bus.in_s_valid = 0; bus.in_w_valid = 0;
    @(negedge in_clk);
    in_rst = 0;
    @(negedge in_clk);

    // vector table
    for (int v = 0; v < 7; v++) begin
      @(negedge in_clk);
      if (vecs[v].is_wr) begin
        bus.in_w_valid = 1; bus.in_w_addr = vecs[v].waddr;
        bus.in_w_data = vecs[v].wdata; bus.in_w_mask = vecs[v].wmask;
      end else begin
        bus.in_s_valid = 1; bus.in_s_key = vecs[v].key;
      end
      #1;
      t = 0;
      while (!(vecs[v].is_wr ? bus.out_w_ready : bus.out_s_ready) && t < 20) begin
        @(negedge in_clk); #1; t++;
      end
      check($sformatf("vec%0d_ready", v), vecs[v].is_wr ? bus.out_w_ready : bus.out_s_ready, 1);
      @(negedge in_clk);
      bus.in_s_valid = 0; bus.in_w_valid = 0;
      check($sformatf("vec%0d_pins", v),
            {bus.out_tcam_csb, bus.out_tcam_web, bus.out_tcam_wmask, bus.out_tcam_addr, bus.out_tcam_wdata},
            {1'b0, vecs[v].exp_web, vecs[v].exp_wmask, vecs[v].exp_addr, vecs[v].exp_wdata});
      if (vecs[v].is_wr) begin
        @(negedge in_clk);
        check($sformatf("vec%0d_one_cycle", v), bus.out_tcam_csb, 1);
      end else begin
        bus.in_r_ready = 1;
        n = 0;
        while (!bus.out_r_valid && n < 10) begin @(negedge in_clk); n++; end
        check($sformatf("vec%0d_latency", v), n, SEARCH_LAT + 1);
        check($sformatf("vec%0d_pma", v), bus.out_r_pma, vecs[v].exp_pma);
        @(negedge in_clk);
        bus.in_r_ready = 0;
        check($sformatf("vec%0d_rvalid_drop", v), bus.out_r_valid, 0);
      end
    end

    // search with result held under backpressure
    @(negedge in_clk);
    bus.in_s_valid = 1; bus.in_s_key = 28'h0ABCDEF; bus.in_r_ready = 0;
    @(negedge in_clk);
    bus.in_s_valid = 0;
    check("hold_issue", {bus.out_tcam_csb, bus.out_tcam_web, bus.out_tcam_addr}, {1'b0, 1'b1, 28'h0ABCDEF});
    @(negedge in_clk);
    check("hold_issue_one_cycle", {bus.out_tcam_csb, bus.out_r_valid}, {1'b1, 1'b0});
    @(negedge in_clk);
    check("hold_first", {bus.out_r_valid, bus.out_r_pma}, {1'b1, 6'd17});
    for (int i = 0; i < 3; i++) begin
      @(negedge in_clk);
      check($sformatf("hold_cycle%0d", i), {bus.out_r_valid, bus.out_r_pma}, {1'b1, 6'd17});
    end
    bus.in_r_ready = 1;
    @(negedge in_clk);
    bus.in_r_ready = 0;
    check("hold_released", bus.out_r_valid, 0);

    // starvation ordering
    @(negedge in_clk);
    bus.in_s_valid = 1; bus.in_w_valid = 1; bus.in_r_ready = 1;
    bus.in_s_key = 28'h0000123; bus.in_w_addr = 10'h011; bus.in_w_data = 32'h1; bus.in_w_mask = 4'h1;
    order = "";
    t = 0;
    while (order.len() < 10 && t < 200) begin
      #1;
      if (bus.out_s_ready) order = {order, "S"};
      else if (bus.out_w_ready) order = {order, "W"};
      @(negedge in_clk);
      t++;
    end
    bus.in_s_valid = 0; bus.in_w_valid = 0; bus.in_r_ready = 0;
    checks++;
    if (order != "SSSSWSSSSW") begin
      failures++;
      $display("FAIL starve_order: got %s expected SSSSWSSSSW", order);
    end
    repeat (6) @(negedge in_clk);
    bus.in_r_ready = 1;
    repeat (3) @(negedge in_clk);
    bus.in_r_ready = 0;

    // asynchronous reset in the middle of a search issue cycle
    @(negedge in_clk);
    bus.in_s_valid = 1; bus.in_s_key = 28'h0000456;
    @(negedge in_clk);
    bus.in_w_valid = 1;
    #2 in_rst = 1;
    #1;
    check("arst_pins", {bus.out_tcam_csb, bus.out_tcam_web, bus.out_tcam_addr}, {1'b1, 1'b1, 28'h0});
    check("arst_rvalid_busy", {bus.out_r_valid, bus.out_busy}, 0);
    check("arst_readys", {bus.out_s_ready, bus.out_w_ready}, 0);
    @(negedge in_clk);
    bus.in_s_valid = 0; bus.in_w_valid = 0;
    in_rst = 0;
    repeat (3) @(negedge in_clk);
    check("arst_abandoned", {bus.out_tcam_csb, bus.out_r_valid}, {1'b1, 1'b0});

    // clear requested while a result is waiting
    bus.in_s_valid = 1; bus.in_s_key = 28'h0000ABC;
    @(negedge in_clk);
    bus.in_s_valid = 0;
    t = 0;
    while (!bus.out_r_valid && t < 10) begin @(negedge in_clk); t++; end
    check("clr_result_seen", bus.out_r_valid, 1);
    bus.in_clear = 1;
    @(negedge in_clk);
    bus.in_clear = 0; bus.in_s_valid = 1; bus.in_w_valid = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check($sformatf("clr_wait%0d", i), {bus.out_busy, bus.out_r_valid, bus.out_s_ready}, {1'b0, 1'b1, 1'b0});
      @(negedge in_clk);
    end
    bus.in_r_ready = 1;
    @(negedge in_clk);
    bus.in_r_ready = 0;
    #1;
    check("clr_pend_gate", {bus.out_s_ready, bus.out_w_ready, bus.out_r_valid, bus.out_busy}, 0);
    @(negedge in_clk);
    bad = 0;
    for (int i = 0; i < CLEAR_WORDS; i++) begin
      if (bus.out_tcam_csb !== 1'b0 || bus.out_tcam_web !== 1'b0 || bus.out_tcam_addr !== 28'(i) ||
          bus.out_tcam_wdata !== 32'h0 || bus.out_tcam_wmask !== 4'hF || bus.out_busy !== 1'b1 ||
          bus.out_s_ready !== 1'b0 || bus.out_w_ready !== 1'b0) bad++;
      @(negedge in_clk);
    end
    check("clr_words_bad", bad, 0);
    check("clr_done", {bus.out_busy, bus.out_tcam_csb}, {1'b0, 1'b1});
    bus.in_s_valid = 0; bus.in_w_valid = 0;

    // reset during a clear at word 300
    @(negedge in_clk);
    bus.in_clear = 1;
    @(negedge in_clk);
    bus.in_clear = 0;
    t = 0;
    while (!(bus.out_busy === 1'b1 && bus.out_tcam_addr === 28'd300) && t < 1200) begin
      @(negedge in_clk); t++;
    end
    check("clr300_reached", bus.out_tcam_addr, 28'd300);
    #2 in_rst = 1;
    #1;
    check("clr300_rst", {bus.out_busy, bus.out_tcam_csb, bus.out_tcam_web}, {1'b0, 1'b1, 1'b1});
    @(negedge in_clk);
    in_rst = 0;
    @(negedge in_clk);
    k = 28'h1234567;
    bus.in_s_valid = 1; bus.in_s_key = k;
    #1;
    check("post_rst_s_ready", bus.out_s_ready, 1);
    @(negedge in_clk);
    bus.in_s_valid = 0; bus.in_r_ready = 1;
    bad = 0; got = 0; pma_got = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_tcam_csb === 1'b0 && bus.out_tcam_web === 1'b0) bad++;
      if (bus.out_busy !== 1'b0) bad++;
      if (bus.out_r_valid === 1'b1 && got == 0) begin got = 1; pma_got = bus.out_r_pma; end
      @(negedge in_clk);
    end
    bus.in_r_ready = 0;
    check("post_rst_no_clear", bad, 0);
    check("post_rst_result", {got[0], pma_got}, {1'b1, pma_of(k)});
    repeat (2) @(negedge in_clk);

    // randomized traffic against a transaction-level model
    free_at = 0; res_pend = 0; res_due = 0; res_pma = '0; starve = 0;
    op_v = 0; op_cyc = -1; op_wr = 0; op_addr = '0; op_data = '0; op_mask = '0;
    starve_hit = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge in_clk);
      if (op_v && op_cyc == c)
        check("rnd_pins",
              {bus.out_tcam_csb, bus.out_tcam_web, bus.out_tcam_wmask, bus.out_tcam_addr, bus.out_tcam_wdata},
              {1'b0, !op_wr, op_mask, op_addr, op_data});
      else
        check("rnd_pins_idle",
              {bus.out_tcam_csb, bus.out_tcam_web, bus.out_tcam_wmask, bus.out_tcam_addr, bus.out_tcam_wdata},
              {1'b1, 1'b1, 4'h0, 28'h0, 32'h0});
      check("rnd_rvalid", bus.out_r_valid, res_pend && c >= res_due);
      if (res_pend && c >= res_due) check("rnd_pma", bus.out_r_pma, res_pma);
      check("rnd_busy", bus.out_busy, 0);

      bus.in_s_valid = ($urandom_range(0, 9) < 6);
      bus.in_s_key   = 28'($urandom());
      bus.in_w_valid = ($urandom_range(0, 9) < 5);
      bus.in_w_addr  = 10'($urandom());
      bus.in_w_data  = $urandom();
      bus.in_w_mask  = 4'($urandom());
      bus.in_r_ready = ($urandom_range(0, 9) < 7);
      #1;

      free_m = (c >= free_at) && !res_pend;
      exp_sr = free_m && !(bus.in_w_valid && starve == STARVE_MAX);
      exp_wr = free_m && ((bus.in_w_valid && starve == STARVE_MAX) ? 1'b1 : !bus.in_s_valid);
      if (free_m && bus.in_w_valid && starve == STARVE_MAX) starve_hit = 1;
      check("rnd_readys", {bus.out_s_ready, bus.out_w_ready}, {exp_sr, exp_wr});
      gs = bus.in_s_valid && exp_sr;
      gw = bus.in_w_valid && exp_wr;

      if (res_pend && c >= res_due && bus.in_r_ready) begin
        res_pend = 0;
        free_at  = c + 1;
      end
      if (!bus.in_w_valid || gw) starve = 0;
      else if (gs && starve < STARVE_MAX) starve++;

      if (gs) begin
        op_v = 1; op_cyc = c + 1; op_wr = 0;
        op_addr = bus.in_s_key; op_data = '0; op_mask = '0;
        res_pend = 1; res_due = c + 2 + SEARCH_LAT; res_pma = pma_of(bus.in_s_key);
      end else if (gw) begin
        op_v = 1; op_cyc = c + 1; op_wr = 1;
        op_addr = {18'h0, bus.in_w_addr}; op_data = bus.in_w_data; op_mask = bus.in_w_mask;
        free_at = c + 2;
      end
    end
    bus.in_s_valid = 0; bus.in_w_valid = 0; bus.in_r_ready = 1;
    if (!starve_hit) $display("note: random phase never reached the starvation limit");
    repeat (6) @(negedge in_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcam_ctrl.md
# tcam_ctrl

Sequencing controller in front of the 28-bit-key / 6-bit-PMA TCAM macro. Arbitrates a search requester and a write requester onto the macro's single shared port, and drives the macro's chip-select, write-enable, mask, address and data pins. Captures the priority-match address after a fixed latency and runs an autonomous clear sequence that zeroes all 1024 macro words. Sits between the RoCC command decoder and the TCAM macro.

## Interface
- ADDR_W, 28, search key / macro address width
- DATA_W, 32, write data width
- WADDR_W, 10, write word address: [9:8] block, [7:0] row
- PMA_W, 6, priority match address width
- SEARCH_LAT, 1, cycles from macro sampling a search to in_tcam_pma valid (1..3)
- STARVE_MAX, 4, consecutive search grants allowed while a write is pending

Ports:
- in_clk  in  1  clock
- in_rst  in  1  reset, asynchronous, active-high
- in_s_valid / out_s_ready  in/out  1  search request handshake
- in_s_key  in  ADDR_W  search key
- out_r_valid / in_r_ready  out/in  1  search result handshake
- out_r_pma  out  PMA_W  match address
- in_w_valid / out_w_ready  in/out  1  write request handshake
- in_w_addr  in  WADDR_W  word address
- in_w_data  in  DATA_W  write data
- in_w_mask  in  4  byte mask
- in_clear  in  1  clear-start pulse
- out_busy  out  1  clear in progress
- out_tcam_csb / out_tcam_web  out  1  macro chip select (active low) / write enable (low = write)
- out_tcam_wmask  out  4  macro byte mask
- out_tcam_addr  out  ADDR_W  macro address
- out_tcam_wdata  out  DATA_W  macro write data
- in_tcam_pma  in  PMA_W  macro match output

## Operation
- States: IDLE, WRITE, S_ISSUE, S_WAIT, RESULT, CLEAR.
- A handshake completes on a rising edge with valid & ready both high.
- Ready gating: out_s_ready and out_w_ready are 0 while in_rst is high and in any state other than IDLE.
- IDLE arbitration, highest priority first:
  - clear_pend: go to CLEAR; both readys are 0.
  - Write starved (in_w_valid high and starve_cnt == STARVE_MAX): only out_w_ready = 1.
  - Otherwise: search wins. out_s_ready = 1; out_w_ready = !in_s_valid. This is a combinational path from in_s_valid.
- starve_cnt:
  - Increments on each search grant made while in_w_valid is high.
  - Clears on any write grant, or when in_w_valid is low.
  - Saturates at STARVE_MAX.
- clear_pend:
  - Set by in_clear in any state.
  - Cleared on entry to CLEAR.
  - in_clear pulses while already in CLEAR are ignored.
- WRITE (1 cycle): drive csb=0, web=0, wmask=mask, addr={zeros, w_addr}, wdata=data. Next state IDLE.
- S_ISSUE (1 cycle): drive csb=0, web=1, addr=key, wmask=0, wdata=0. Next state S_WAIT.
- S_WAIT: lasts SEARCH_LAT cycles. On its final edge, register in_tcam_pma into out_r_pma. Next state RESULT.
- RESULT: out_r_valid=1 and out_r_pma held stable until in_r_ready. Return to IDLE on the accept edge. Only one search is outstanding at a time.
- CLEAR:
  - 10-bit counter runs 0..1023.
  - Each cycle drives csb=0, web=0, wmask=4'hF, wdata=0, addr=counter.
  - out_busy=1 throughout CLEAR.
  - Returns to IDLE after word 0x3FF.
- Idle macro pins, in every state without an issue: csb=1, web=1, all other macro outputs 0.

## Timing
- All outputs are registered, except out_s_ready and out_w_ready.
- Reset values: state IDLE, csb=1, web=1, wmask/addr/wdata=0, out_r_valid=0, out_r_pma=0, out_busy=0, counters and clear_pend 0.
- Search accepted at edge E:
  - Macro issue occupies cycle E+1.
  - out_r_valid rises after edge E+1+SEARCH_LAT.
  - With in_r_ready held high, next out_s_ready is one cycle later.
- Write accepted at edge E: macro write occupies cycle E+1. Maximum rate is one write per 2 cycles.
- Clear: out_busy rises the cycle after the IDLE decision and stays high for exactly 1024 cycles.
- Reset mid-operation: any state returns immediately to IDLE with reset values. A partially complete clear is abandoned and is not resumed.

## Structure
- tcam_pkg holds:
  - state enum
  - ADDR_W, DATA_W, WADDR_W, PMA_W defaults
  - CLEAR_WORDS = 1024
- One sub-module, tcam_arb: IDLE grant logic, starve_cnt and clear_pend. It outputs grant_s, grant_w and grant_clr.

## Test plan
- Reset: assert in_rst mid-cycle, asynchronously -> csb=1, web=1, out_r_valid=0, out_busy=0, both readys 0 while reset is high.
- Search: key 0x0ABCDEF, model returns pma 17 with SEARCH_LAT=1 -> for exactly 1 cycle: addr=0x0ABCDEF, csb=0, web=1. Then out_r_valid with pma 17, held 3 cycles under in_r_ready=0.
- Write: addr 0x2C5, data 0xDEADBEEF, mask 0x5 -> one cycle with csb=0, web=0, addr=0x00002C5, wdata=0xDEADBEEF, wmask=0x5.
- Starvation: in_s_valid and in_w_valid both held high with STARVE_MAX=4 -> grant order S,S,S,S,W, repeating.
- Clear: pulse in_clear while a search is in RESULT -> clear starts after the result is accepted. Then 1024 consecutive writes to addresses 0..0x3FF with wdata=0 and wmask=0xF, with out_busy high. Readys are 0 throughout.
- Reset during clear at word 300 -> after reset, a new search is accepted with no further clear writes.
